// File: rtl/jk_counter_pkg.sv
// Shared JK excitation encoding, excitation helper and parameter legality check
// for the JK-based modulo counter.
package jk_counter_pkg;

    // {j,k} encodings understood by jk_flip_flop
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    localparam int MIN_WIDTH   = 1;
    localparam int MAX_WIDTH   = 16;
    localparam int MIN_MODULUS = 2;

    // Map a desired next state onto the JK inputs; never yields JK_TOGGLE.
    function automatic logic [1:0] jk_excite(input logic n, input logic q);
        return {n & ~q, ~n & q};
    endfunction

    function automatic bit params_ok(input int width, input int modulus);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
               (modulus >= MIN_MODULUS) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/jk_flip_flop.sv
// Single JK flip-flop cell with synchronous active-high reset.
module jk_flip_flop
    import jk_counter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: next-value logic drives JK excitation for a chain
// of jk_flip_flop stages, plus cascade terminal count and load error flag.
module jk_mod_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             terminal_count,
    output logic             load_err
);

    generate
        if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
            $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_bar;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_load_ok;
    logic             w_at_max;
    logic             w_at_zero;
    logic             r_load_err;

    assign w_load_ok = ({1'b0, load_value} < MOD_EXT);
    assign w_at_max  = (w_q == MAX_VAL);
    assign w_at_zero = (w_q == '0);

    // Hold falls out naturally: w_next == w_q gives J=K=0 on every stage.
    always_comb begin
        w_next = w_q;
        if (load) begin
            w_next = w_load_ok ? load_value : '0;
        end else if (enable) begin
            if (up_down) begin
                w_next = w_at_max ? '0 : (w_q + WIDTH'(1));
            end else begin
                w_next = w_at_zero ? MAX_VAL : (w_q - WIDTH'(1));
            end
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_stage
            assign {w_j[i], w_k[i]} = jk_excite(w_next[i], w_q[i]);

            jk_flip_flop u_ff (
                .clock (clock),
                .reset (reset),
                .j     (w_j[i]),
                .k     (w_k[i]),
                .q     (w_q[i]),
                .q_bar (w_q_bar[i])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & ~w_load_ok;
        end
    end

    assign terminal_count = enable & ~reset & ~load &
                            ((up_down & w_at_max) | (~up_down & w_at_zero));

    assign count     = w_q;
    assign count_bar = w_q_bar;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios, randomized run
// against an arithmetic reference model, and a two-digit decimal cascade.
module tb_jk_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clock = 1'b0;
    logic         reset, enable, up_down, load;
    logic [W-1:0] load_value;
    logic [W-1:0] count, count_bar;
    logic         terminal_count, load_err;

    // cascade pair
    logic         c_reset, c_enable;
    logic [W-1:0] u_count, u_count_bar, t_count, t_count_bar;
    logic         u_tc, t_tc, u_err, t_err;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_count;
    bit m_err;

    always #5 clock = ~clock;

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .count(count),
        .count_bar(count_bar), .terminal_count(terminal_count), .load_err(load_err)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_units (
        .clock(clock), .reset(c_reset), .enable(c_enable), .up_down(1'b1),
        .load(1'b0), .load_value('0), .count(u_count),
        .count_bar(u_count_bar), .terminal_count(u_tc), .load_err(u_err)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_tens (
        .clock(clock), .reset(c_reset), .enable(u_tc), .up_down(1'b1),
        .load(1'b0), .load_value('0), .count(t_count),
        .count_bar(t_count_bar), .terminal_count(t_tc), .load_err(t_err)
    );

    // Inputs are changed 1 time unit after a rising edge, then allowed to settle.
    task automatic set_in(input bit r, input bit l, input int lv, input bit e, input bit ud);
        reset = r; load = l; load_value = W'(lv); enable = e; up_down = ud;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int model_next(input int c, input bit r, input bit l, input int lv,
                                      input bit e, input bit ud);
        if (r) return 0;
        if (l) return (lv < MOD) ? lv : 0;
        if (e) return ud ? (c + 1) % MOD : (c + MOD - 1) % MOD;
        return c;
    endfunction

    function automatic bit model_tc(input int c, input bit r, input bit l, input bit e, input bit ud);
        return e && !r && !l && ((ud && c == MOD - 1) || (!ud && c == 0));
    endfunction

    task automatic test_reset();
        set_in(1, 0, 0, 1, 1);
        step();
        n_checks++;
        if (terminal_count !== 1'b0) begin
            n_fail++; $display("FAIL reset_tc: got %b want 0", terminal_count);
        end
        step();
        n_checks++;
        if (count !== '0 || count_bar !== '1 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d bar=%b err=%b want 0/1111/0", count, count_bar, load_err);
        end
    endtask

    task automatic test_up_count();
        set_in(0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (terminal_count !== ((i % MOD) == MOD - 1)) begin
                n_fail++; $display("FAIL up_tc[%0d]: got %b at count %0d", i, terminal_count, count);
            end
            step();
            n_checks++;
            if (count !== W'((i + 1) % MOD) || count_bar !== ~count) begin
                n_fail++;
                $display("FAIL up_count[%0d]: got %0d bar=%b want %0d", i, count, count_bar, (i + 1) % MOD);
            end
        end
    endtask

    task automatic test_down_wrap();
        set_in(1, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 1, 0);
        n_checks++;
        if (terminal_count !== 1'b1) begin
            n_fail++; $display("FAIL down_tc_at_zero: got %b want 1", terminal_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (count !== W'(MOD - 1 - i)) begin
                n_fail++; $display("FAIL down_wrap[%0d]: got %0d want %0d", i, count, MOD - 1 - i);
            end
        end
    endtask

    task automatic test_loads();
        set_in(0, 1, 7, 0, 1);
        step();
        n_checks++;
        if (count !== 4'd7 || load_err !== 1'b0) begin
            n_fail++; $display("FAIL load_7: count=%0d err=%b want 7/0", count, load_err);
        end
        set_in(0, 1, 12, 0, 1);
        step();
        n_checks++;
        if (count !== 4'd0 || load_err !== 1'b1) begin
            n_fail++; $display("FAIL load_12: count=%0d err=%b want 0/1", count, load_err);
        end
        set_in(0, 0, 0, 0, 1);
        step();
        n_checks++;
        if (load_err !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL load_err_pulse: err=%b count=%0d want 0/0", load_err, count);
        end
    endtask

    task automatic test_priority_hold();
        set_in(0, 1, 5, 0, 1);
        step();
        set_in(0, 1, 3, 1, 1);
        n_checks++;
        if (terminal_count !== 1'b0) begin
            n_fail++; $display("FAIL load_forces_tc: got %b want 0", terminal_count);
        end
        step();
        n_checks++;
        if (count !== 4'd3) begin
            n_fail++; $display("FAIL load_beats_enable: got %0d want 3", count);
        end
        set_in(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (count !== 4'd3 || terminal_count !== 1'b0) begin
                n_fail++; $display("FAIL hold[%0d]: count=%0d tc=%b want 3/0", i, count, terminal_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 1, 6, 0, 1);
        step();
        set_in(1, 0, 0, 1, 1);
        step();
        n_checks++;
        if (count !== 4'd0 || load_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: count=%0d err=%b want 0/0", count, load_err);
        end
        set_in(0, 0, 0, 1, 1);
        step();
        n_checks++;
        if (count !== 4'd1) begin
            n_fail++; $display("FAIL resume_after_reset: got %0d want 1", count);
        end
    endtask

    task automatic test_random();
        bit r, l, e, ud;
        int lv;
        m_count = int'(count);
        m_err   = load_err;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 31) == 0);
            l  = ($urandom_range(0, 7) == 0);
            lv = $urandom_range(0, 15);
            e  = ($urandom_range(0, 3) != 0);
            ud = $urandom_range(0, 1);
            set_in(r, l, lv, e, ud);
            n_checks++;
            if (terminal_count !== model_tc(m_count, r, l, e, ud)) begin
                n_fail++;
                $display("FAIL rand_tc[%0d]: got %b want %b", i, terminal_count, model_tc(m_count, r, l, e, ud));
            end
            m_err   = !r && l && (lv >= MOD);
            m_count = model_next(m_count, r, l, lv, e, ud);
            step();
            n_checks++;
            if (count !== W'(m_count) || count_bar !== ~W'(m_count) || load_err !== m_err) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: count=%0d bar=%b err=%b want %0d/%b", i, count, count_bar,
                         load_err, m_count, m_err);
            end
        end
    endtask

    task automatic test_cascade();
        int total = 0;
        c_reset = 1'b1; c_enable = 1'b0;
        step();
        step();
        c_reset = 1'b0; c_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            total++;
            n_checks++;
            if (u_count !== W'(total % 10) || t_count !== W'((total / 10) % 10)) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got %0d%0d want %0d", i, t_count, u_count, total % 100);
            end
        end
        n_checks++;
        if (u_count !== 4'd0 || t_count !== 4'd0) begin
            n_fail++; $display("FAIL cascade_rollover: got %0d%0d want 00", t_count, u_count);
        end
    endtask

    initial begin
        c_reset = 1'b1; c_enable = 1'b0;
        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0;
        step();
        test_reset();
        test_up_count();
        test_down_wrap();
        test_loads();
        test_priority_hold();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
